sar_adc_ctrl: RTL and testbench
===============================

Name: sar_adc_ctrl

Overview:
- Successive-approximation ADC controller that reads an analog input through the board's 10-bit R-2R DAC plus one external comparator.
- Drives a trial code onto the DAC, waits for settling, samples the comparator and resolves one bit per step, MSB first.
- Sits beside the waveform generator on the same DAC pins, as the measure/read-back path of the DAC interface.
- A top-level mux maps dac_code onto the DAC pins with bit 0 = LSB.

Parameters:
- N_BITS, 10, conversion width; equals DAC width.
- SETTLE_CYCLES, 4, cycles each trial code is held before the comparator is evaluated; must be >= 3 so it covers the 2-flop synchronizer. Lower values are rejected at elaboration.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  conversion request, sampled in IDLE only
- comp_in  input  1  raw comparator output, asynchronous; 1 = Vin >= Vdac
- dac_code  output  N_BITS  trial code driven to the R-2R DAC
- busy  output  1  high while a conversion is in progress
- result  output  N_BITS  last completed conversion
- valid  output  1  one-cycle pulse when result updates

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While rst_n=0: state=IDLE, dac_code=0, result=0, valid=0, busy=0, bit index=0, settle counter=0, sync flops=0.
  - Reset asserted mid-conversion aborts immediately with the same values; no valid is produced.
- comp_in passes through a 2-flop synchronizer to give comp_s. Only comp_s is used.
- States: IDLE, SETTLE, DECIDE.
- IDLE:
  - busy=0; dac_code holds its last value.
  - On start=1: next state SETTLE, dac_code = 1<<(N_BITS-1), idx = N_BITS-1, cnt = SETTLE_CYCLES-1, busy=1.
- SETTLE:
  - cnt decrements each cycle.
  - When cnt==0, next state is DECIDE.
  - SETTLE lasts exactly SETTLE_CYCLES cycles.
- DECIDE (1 cycle):
  - If comp_s=0, clear dac_code[idx]; otherwise keep it.
  - If idx>0: set dac_code[idx-1], idx--, cnt = SETTLE_CYCLES-1, next state SETTLE.
  - If idx==0: result <= final code (including the bit-0 decision), valid <= 1 for one cycle, busy <= 0, next state IDLE.
- Latency:
  - start sampled at edge 0; the final DECIDE edge is edge N_BITS*(SETTLE_CYCLES+1), i.e. edge 50 at defaults.
  - valid is high for the cycle after that edge.
  - The earliest next start is sampled at the following edge, giving 51-cycle spacing when start is held high.
- start while busy is ignored and not queued.
- result is stable between valid pulses.
- Code arithmetic is bitwise only; no wrap is possible.
  - All-ones input converges to 2^N_BITS-1.
  - Zero input converges to 0.

Optional Feature:
- Macro SAR_CONTINUOUS_EN.
- Defined:
  - On the final DECIDE, state goes directly to SETTLE with dac_code = 1<<(N_BITS-1), idx = N_BITS-1, cnt = SETTLE_CYCLES-1.
  - busy stays 1 and start is ignored.
  - valid pulses every N_BITS*(SETTLE_CYCLES+1) cycles (50 at defaults) after the first start.
  - The first conversion still requires start.
  - Reset returns to IDLE.
- Undefined: single-shot behaviour as described above.

Test Plan:
- Bench comparator model: comp_in = (vin >= dac_code). With vin=0x2A5, pulse start -> busy high after edge 0; valid high for exactly 1 cycle after edge 50; result=0x2A5; busy low with valid.
- vin=0x000 -> result=0x000. vin=0x3FF -> result=0x3FF. vin=0x200 -> result=0x200. Trial-code sequence for 0x2A5 starts 0x200, 0x300, 0x280, 0x2C0, 0x2A0, ...
- Pulse start again at edge 20 during a conversion -> ignored; only one valid, at edge 50; no second conversion.
- Deassert rst_n at edge 25 -> dac_code, busy, result and valid all 0 immediately (asynchronous). Release rst_n and pulse start with vin=0x155 -> result=0x155 after 50 cycles.
- Glitch comp_in for less than 1 cycle mid-SETTLE, returning to the true level before the DECIDE sample -> result unaffected.
- With SAR_CONTINUOUS_EN and vin=0x0F0: one start -> valid pulses at 50-cycle spacing, result=0x0F0 each time. Change vin to 0x321 before a conversion begins -> the next result is 0x321.

Source files
------------

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: drives trial codes onto the R-2R DAC and resolves one bit
// per step from a synchronized comparator. Define SAR_CONTINUOUS_EN for back-to-back conversions.
`timescale 1ns/1ps
module sar_adc_ctrl #(
    parameter int N_BITS        = 10,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              comp_in,
    output logic [N_BITS-1:0] dac_code,
    output logic              busy,
    output logic [N_BITS-1:0] result,
    output logic              valid
);
    localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int CNT_W = $clog2(SETTLE_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_TOP  = IDX_W'(N_BITS - 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [N_BITS-1:0] MSB_CODE = N_BITS'(1) << (N_BITS - 1);

    // The settle window must outlast the two synchronizer flops, or DECIDE sees a stale comparator.
    generate
        if (SETTLE_CYCLES < 3) begin : g_bad_settle
            $error("sar_adc_ctrl: SETTLE_CYCLES must be at least 3");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SETTLE, DECIDE} state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_dn;
    logic [CNT_W-1:0]   cnt;
    logic               comp_m;
    logic               comp_s;
    logic [N_BITS-1:0]  decided;
    logic [N_BITS-1:0]  next_trial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comp_m <= 1'b0;
            comp_s <= 1'b0;
        end else begin
            comp_m <= comp_in;
            comp_s <= comp_m;
        end
    end

    assign idx_dn = idx - IDX_W'(1);

    always_comb begin
        decided = dac_code;
        if (!comp_s) begin
            decided[idx] = 1'b0;
        end
        next_trial = decided;
        if (idx != '0) begin
            next_trial[idx_dn] = 1'b1;
        end
    end

    // start is a level request honoured only in IDLE; valid is a one-cycle pulse with no
    // back-pressure, and result holds its value until the next valid pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dac_code <= '0;
            result   <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            idx      <= '0;
            cnt      <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SETTLE;
                        dac_code <= MSB_CODE;
                        idx      <= IDX_TOP;
                        cnt      <= CNT_LOAD;
                        busy     <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state <= DECIDE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DECIDE: begin
                    if (idx != '0) begin
                        dac_code <= next_trial;
                        idx      <= idx_dn;
                        cnt      <= CNT_LOAD;
                        state    <= SETTLE;
                    end else begin
                        result <= decided;
                        valid  <= 1'b1;
`ifdef SAR_CONTINUOUS_EN
                        dac_code <= MSB_CODE;
                        idx      <= IDX_TOP;
                        cnt      <= CNT_LOAD;
                        state    <= SETTLE;
`else
                        dac_code <= decided;
                        busy     <= 1'b0;
                        state    <= IDLE;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Self-checking bench for sar_adc_ctrl: ideal comparator (vin >= dac_code), a cycle-level model
// derived from the SAR trial-code rule, and directed conversions with hand-computed results.
`timescale 1ns/1ps
module tb_sar_adc_ctrl;
    localparam int N    = 10;
    localparam int S    = 4;
    localparam int STEP = S + 1;
    localparam int CONV = N * STEP;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         comp_in;
    logic [N-1:0] dac_code;
    logic         busy;
    logic [N-1:0] result;
    logic         valid;

    logic [N-1:0] vin;
    logic         glitch;
    logic         check_en = 1'b0;
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;

    // Model state: conversion timing and the expected-result scoreboard
    logic         m_active = 1'b0;
    int           m_t0 = 0;
    logic [N-1:0] m_vin = '0;
    logic [N-1:0] m_result = '0;
    logic [N-1:0] m_dac_last = '0;
    int           m_valid_edge = -1;
    logic [N-1:0] exp_q[$];
    logic [N-1:0] trial_cap[5];

    sar_adc_ctrl #(.N_BITS(N), .SETTLE_CYCLES(S)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .comp_in  (comp_in),
        .dac_code (dac_code),
        .busy     (busy),
        .result   (result),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    assign comp_in = (vin >= dac_code) ^ glitch;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Trial k keeps the k already-resolved MSBs of vin and tries the next bit down.
    function automatic logic [N-1:0] trial_code(input logic [N-1:0] v, input int k);
        int vi;
        int keep;
        vi   = int'(v);
        keep = N - k;
        return N'(((vi >> keep) << keep) | (1 << (N - 1 - k)));
    endfunction

    always @(negedge rst_n) begin
        m_active     = 1'b0;
        m_result     = '0;
        m_dac_last   = '0;
        m_valid_edge = -1;
    end

    always @(posedge clk) begin
        int t;
        cyc++;
        if (rst_n) begin
            if (m_active) begin
                t = cyc - m_t0;
                if (t == 1) m_vin = vin;
                if (t == CONV) begin
                    m_result     = m_vin;
                    m_dac_last   = m_vin;
                    m_valid_edge = cyc;
                    exp_q.push_back(m_vin);
`ifdef SAR_CONTINUOUS_EN
                    m_t0 = cyc;
`else
                    m_active = 1'b0;
`endif
                end
            end else if (start) begin
                m_active = 1'b1;
                m_t0     = cyc;
            end
        end
    end

    always @(negedge clk) begin
        logic         e_busy;
        logic [N-1:0] e_dac;
        if (check_en) begin
            if (m_active) begin
                e_busy = 1'b1;
                e_dac  = trial_code(m_vin, (cyc - m_t0) / STEP);
            end else begin
                e_busy = 1'b0;
                e_dac  = m_dac_last;
            end
            check("busy", 32'(busy), 32'(e_busy));
            check("dac_code", 32'(dac_code), 32'(e_dac));
            check("valid", 32'(valid), 32'(m_valid_edge == cyc));
            check("result", 32'(result), 32'(m_result));
            if (valid) begin
                if (exp_q.size() == 0) check("sb_unexpected_valid", 32'(1), 32'(0));
                else check("sb_result", 32'(result), 32'(exp_q.pop_front()));
            end
        end
    end

    // Pulses start, then counts negedges after the start edge until valid (bounded).
    task automatic do_conv(input logic [N-1:0] v, input int glitch_n, input int restart_n,
                           input int abort_n, output int n);
        vin = v;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        trial_cap[0] = dac_code;
        while (n < 200) begin
            if (n == glitch_n) begin
                glitch = 1'b1;
                @(posedge clk);
                #2 glitch = 1'b0;
            end
            if (n == abort_n) begin
                @(posedge clk);
                #2 rst_n = 1'b0;
                return;
            end
            @(negedge clk);
            n++;
            start = (n == restart_n);
            if (n % STEP == 0 && n < 5 * STEP) trial_cap[n / STEP] = dac_code;
            if (valid) break;
        end
        start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid && n < 200);
    endtask

    initial begin
        int n;
        int extra;
        logic [N-1:0] vecs[3] = '{10'h000, 10'h3FF, 10'h200};
        rst_n = 1'b0; start = 1'b0; vin = '0; glitch = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_dac", 32'(dac_code), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_valid", 32'(valid), 32'(0));
        check("reset_result", 32'(result), 32'(0));
        check("model_trial3", 32'(trial_code(10'h2A5, 3)), 32'(10'h2C0));
        check("model_trial4", 32'(trial_code(10'h2A5, 4)), 32'(10'h2A0));
        rst_n = 1'b1;
        check_en = 1'b1;
        @(negedge clk);

`ifdef SAR_CONTINUOUS_EN
        do_conv(10'h0F0, -1, -1, -1, n);
        check("cont_first_latency", 32'(n), 32'(50));
        check("cont_first_result", 32'(result), 32'(10'h0F0));
        check("cont_busy_after_valid", 32'(busy), 32'(1));
        wait_valid(n);
        check("cont_spacing", 32'(n), 32'(50));
        check("cont_second_result", 32'(result), 32'(10'h0F0));
        vin = 10'h321;
        wait_valid(n);
        check("cont_spacing2", 32'(n), 32'(50));
        check("cont_new_vin_result", 32'(result), 32'(10'h321));
        repeat (7) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("cont_rst_busy", 32'(busy), 32'(0));
        check("cont_rst_dac", 32'(dac_code), 32'(0));
        check("cont_rst_result", 32'(result), 32'(0));
        @(negedge clk); rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("cont_idle_after_reset", 32'(busy), 32'(0));
`else
        do_conv(10'h2A5, -1, -1, -1, n);
        check("lat_2a5", 32'(n), 32'(50));
        check("result_2a5", 32'(result), 32'(10'h2A5));
        check("busy_low_with_valid", 32'(busy), 32'(0));
        check("trial0", 32'(trial_cap[0]), 32'(10'h200));
        check("trial1", 32'(trial_cap[1]), 32'(10'h300));
        check("trial2", 32'(trial_cap[2]), 32'(10'h280));
        check("trial3", 32'(trial_cap[3]), 32'(10'h2C0));
        check("trial4", 32'(trial_cap[4]), 32'(10'h2A0));
        @(negedge clk);
        check("valid_one_cycle", 32'(valid), 32'(0));
        check("result_held", 32'(result), 32'(10'h2A5));

        foreach (vecs[i]) begin
            do_conv(vecs[i], -1, -1, -1, n);
            check("lat_vec", 32'(n), 32'(50));
            check("result_vec", 32'(result), 32'(vecs[i]));
        end

        do_conv(10'h1C3, -1, 20, -1, n);
        check("lat_restart_ignored", 32'(n), 32'(50));
        check("result_1c3", 32'(result), 32'(10'h1C3));
        extra = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (valid || busy) extra++;
        end
        check("no_second_conversion", 32'(extra), 32'(0));

        do_conv(10'h2A5, 10, -1, -1, n);
        check("lat_glitch", 32'(n), 32'(50));
        check("result_glitch", 32'(result), 32'(10'h2A5));

        do_conv(10'h2A5, -1, -1, 24, n);
        #1;
        check("abort_dac", 32'(dac_code), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_result", 32'(result), 32'(0));
        check("abort_valid", 32'(valid), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_conv(10'h155, -1, -1, -1, n);
        check("lat_155", 32'(n), 32'(50));
        check("result_155", 32'(result), 32'(10'h155));
`endif
        repeat (5) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'(0));
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
